// File: rtl/atm_note_dispenser_pkg.sv
// Shared encodings for the note dispenser: FSM state codes and note_denom codes.
package atm_note_dispenser_pkg;

    // 3-bit state encoding so the state register can be probed like a display code
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_SELECT = 3'd2,
        ST_OFFER  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5,
        ST_ABORT  = 3'd6
    } state_t;

    localparam logic [1:0] DENOM_NONE = 2'b00;
    localparam logic [1:0] DENOM_HI_C = 2'b01;
    localparam logic [1:0] DENOM_MID_C = 2'b10;
    localparam logic [1:0] DENOM_LO_C = 2'b11;

endpackage

// File: rtl/atm_note_dispenser_if.sv
// Note request handshake between the payout controller and the mechanical dispenser.
interface atm_note_dispenser_if;
    logic       note_valid;
    logic [1:0] note_denom;
    logic       note_ready;

    modport master (output note_valid, output note_denom, input note_ready);
    modport slave  (input note_valid, input note_denom, output note_ready);
endinterface

// File: rtl/atm_note_dispenser_rise_detect.sv
// One-flop rising-edge detector for the success strobe.
module atm_note_dispenser_rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    // Delay flop resets high: a level already high at reset release is not an edge,
    // the input has to be seen low first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sig_q <= 1'b1;
        else        sig_q <= sig_i;
    end

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/atm_note_dispenser.sv
// Greedy note payout controller: splits cash_out into HI/MID/LO notes and offers
// them one at a time on a valid/ready handshake.
//
//  state  | meaning
//  IDLE   | waiting for a success rising edge
//  CHECK  | amount validity / zero check
//  SELECT | pick largest note not exceeding the remainder
//  OFFER  | note_valid held until the dispenser accepts
//  DONE   | 1-cycle done pulse
//  ERROR  | 1-cycle error pulse (amount not a multiple of DENOM_LO)
//  ABORT  | 1-cycle aborted pulse (cancel seen)
module atm_note_dispenser
    import atm_note_dispenser_pkg::*;
#(
    parameter int AMT_W     = 14,
    parameter int DENOM_HI  = 50,
    parameter int DENOM_MID = 20,
    parameter int DENOM_LO  = 10,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 success_i,
    input  logic [AMT_W-1:0]     cash_out_i,
    input  logic                 cancel_i,
    atm_note_dispenser_if.master note_if,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 aborted_o,
    output logic [CNT_W-1:0]     note_count_o
);
    state_t             state_q;
    logic [AMT_W-1:0]   rem_q;
    logic [CNT_W-1:0]   count_q;
    logic [1:0]         denom_q;
    logic               valid_q;
    logic               busy_q;
    logic               done_q;
    logic               error_q;
    logic               aborted_q;

    logic               start_edge;
    logic               transfer;
    logic [AMT_W-1:0]   note_val;
    logic [AMT_W-1:0]   rem_d;
    logic [CNT_W-1:0]   count_d;
    logic               not_multiple;

    atm_note_dispenser_rise_detect u_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (success_i),
        .rise_o (start_edge)
    );

    assign transfer     = valid_q & note_if.note_ready;
    assign not_multiple = (rem_q % AMT_W'(DENOM_LO)) != '0;

    // Value of the note on offer and the datapath results of accepting it
    always_comb begin
        note_val = AMT_W'(DENOM_LO);
        case (denom_q)
            DENOM_HI_C:  note_val = AMT_W'(DENOM_HI);
            DENOM_MID_C: note_val = AMT_W'(DENOM_MID);
            default:     note_val = AMT_W'(DENOM_LO);
        endcase
        // SELECT only offers a note no larger than rem, so this cannot underflow
        rem_d   = rem_q - note_val;
        count_d = (&count_q) ? count_q : count_q + 1'b1;
    end

    // Payout FSM with registered outputs and the rem / note_count datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rem_q     <= '0;
            count_q   <= '0;
            denom_q   <= DENOM_NONE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        rem_q   <= cash_out_i;
                        count_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (cancel_i) begin
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        state_q   <= ST_ABORT;
                    end else if (not_multiple) begin
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                        state_q <= ST_ERROR;
                    end else if (rem_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (cancel_i) begin
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        state_q   <= ST_ABORT;
                    end else begin
                        if (rem_q >= AMT_W'(DENOM_HI))       denom_q <= DENOM_HI_C;
                        else if (rem_q >= AMT_W'(DENOM_MID)) denom_q <= DENOM_MID_C;
                        else                                 denom_q <= DENOM_LO_C;
                        valid_q <= 1'b1;
                        state_q <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // cancel beats a same-cycle transfer: the note is not counted
                    if (cancel_i) begin
                        valid_q   <= 1'b0;
                        denom_q   <= DENOM_NONE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        state_q   <= ST_ABORT;
                    end else if (transfer) begin
                        valid_q <= 1'b0;
                        denom_q <= DENOM_NONE;
                        rem_q   <= rem_d;
                        count_q <= count_d;
                        if (rem_d == '0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_SELECT;
                        end
                    end
                end
                ST_DONE, ST_ERROR, ST_ABORT: state_q <= ST_IDLE;
                default: begin
                    valid_q <= 1'b0;
                    denom_q <= DENOM_NONE;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign note_if.note_valid = valid_q;
    assign note_if.note_denom = denom_q;
    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign error_o            = error_q;
    assign aborted_o          = aborted_q;
    assign note_count_o       = count_q;
endmodule

// File: tb/tb_atm_note_dispenser.sv
// Directed bench for atm_note_dispenser.
module tb_atm_note_dispenser;
    logic        clk;
    logic        rst_n;
    logic        success;
    logic [13:0] cash_out;
    logic        cancel;
    logic        busy, done, error, aborted;
    logic [10:0] note_count;

    atm_note_dispenser_if nif ();

    atm_note_dispenser dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .success_i    (success),
        .cash_out_i   (cash_out),
        .cancel_i     (cancel),
        .note_if      (nif),
        .busy_o       (busy),
        .done_o       (done),
        .error_o      (error),
        .aborted_o    (aborted),
        .note_count_o (note_count)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    logic [1:0] got[$];
    logic       saw_done, saw_error, saw_abort, ended;
    int         idle_denom_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Produces a fresh success edge; returns in the CHECK cycle (N+1)
    task automatic start(input logic [13:0] amt);
        success = 1'b0;
        tick();
        cash_out = amt;
        success  = 1'b1;
        tick();
    endtask

    // Records accepted notes until a done/error/aborted pulse or the cycle budget expires
    task automatic collect(input int max_cyc);
        got.delete();
        saw_done = 0; saw_error = 0; saw_abort = 0; ended = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (nif.note_valid && nif.note_ready) got.push_back(nif.note_denom);
            if (!nif.note_valid && nif.note_denom != 2'b00) idle_denom_bad++;
            if (done)    saw_done  = 1;
            if (error)   saw_error = 1;
            if (aborted) saw_abort = 1;
            if (done || error || aborted) begin
                ended = 1;
                break;
            end
            tick();
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        return (got.size() > i) ? 32'(got[i]) : 32'hdead;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_bad, unstable, xfers, extra;
        rst_n = 1'b0; success = 1'b0; cash_out = '0; cancel = 1'b0;
        nif.note_ready = 1'b0;
        idle_denom_bad = 0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_valid", nif.note_valid, 0);
        check("rst_denom", nif.note_denom, 0);
        check("rst_pulses", {done, error, aborted}, 0);
        check("rst_count", note_count, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // 1: 2500 -> fifty HI notes
        nif.note_ready = 1'b1;
        start(14'd2500);
        check("t1_busy_check", busy, 1);
        check("t1_valid_check", nif.note_valid, 0);
        tick();
        check("t1_valid_select", nif.note_valid, 0);
        tick();
        check("t1_first_valid", nif.note_valid, 1);
        check("t1_first_denom", nif.note_denom, 1);
        collect(300);
        check("t1_ended", ended, 1);
        check("t1_done", saw_done, 1);
        check("t1_notes", got.size(), 50);
        n_bad = 0;
        foreach (got[i]) if (got[i] != 2'b01) n_bad++;
        check("t1_all_hi", n_bad, 0);
        check("t1_busy_at_done", busy, 0);
        check("t1_count", note_count, 50);
        tick();
        check("t1_done_1cyc", done, 0);
        check("t1_count_hold", note_count, 50);

        // 2: 80 -> HI, MID, LO
        start(14'd80);
        collect(60);
        check("t2_done", saw_done, 1);
        check("t2_notes", got.size(), 3);
        check("t2_n0", got_at(0), 1);
        check("t2_n1", got_at(1), 2);
        check("t2_n2", got_at(2), 3);
        check("t2_count", note_count, 3);
        tick();

        // 3: 35 -> error two cycles after the edge; 0 -> immediate done
        start(14'd35);
        check("t3_count_cleared", note_count, 0);
        check("t3_err_early", error, 0);
        check("t3_valid_check", nif.note_valid, 0);
        tick();
        check("t3_error", error, 1);
        check("t3_busy_err", busy, 0);
        check("t3_valid_err", nif.note_valid, 0);
        tick();
        check("t3_error_1cyc", error, 0);
        check("t3_valid_after", nif.note_valid, 0);
        start(14'd0);
        tick();
        check("t3z_done", done, 1);
        check("t3z_count", note_count, 0);
        tick();
        check("t3z_done_1cyc", done, 0);

        // 4: 60 with the dispenser stalled for 20 cycles
        nif.note_ready = 1'b0;
        start(14'd60);
        tick(); tick();
        check("t4_valid", nif.note_valid, 1);
        check("t4_denom", nif.note_denom, 1);
        unstable = 0;
        repeat (20) begin
            tick();
            if (!(nif.note_valid === 1'b1 && nif.note_denom === 2'b01)) unstable++;
        end
        check("t4_stable", unstable, 0);
        check("t4_count_stall", note_count, 0);
        nif.note_ready = 1'b1;
        collect(40);
        check("t4_done", saw_done, 1);
        check("t4_notes", got.size(), 2);
        check("t4_n0", got_at(0), 1);
        check("t4_n1", got_at(1), 3);
        check("t4_count", note_count, 2);
        tick();

        // 5: 200, cancel after the second accepted note
        start(14'd200);
        xfers = 0;
        extra = 0;
        for (int c = 0; c < 40 && xfers < 2; c++) begin
            if (nif.note_valid && nif.note_ready) xfers++;
            if (done) extra++;
            tick();
        end
        check("t5_xfers", xfers, 2);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("t5_aborted", aborted, 1);
        check("t5_busy", busy, 0);
        check("t5_valid", nif.note_valid, 0);
        check("t5_count", note_count, 2);
        tick();
        check("t5_abort_1cyc", aborted, 0);
        repeat (10) begin
            if (done || nif.note_valid) extra++;
            tick();
        end
        check("t5_no_done", extra, 0);

        // 5b: re-edge starts again; cancel beats a simultaneous transfer
        nif.note_ready = 1'b0;
        start(14'd200);
        check("t5b_busy", busy, 1);
        tick(); tick();
        check("t5b_valid", nif.note_valid, 1);
        nif.note_ready = 1'b1;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        nif.note_ready = 1'b0;
        check("t5b_aborted", aborted, 1);
        check("t5b_count", note_count, 0);
        tick();

        // 6: reset mid-payout with success held high through release
        start(14'd100);
        tick(); tick();
        nif.note_ready = 1'b1;
        tick();
        nif.note_ready = 1'b0;
        tick();
        check("t6_pre_busy", busy, 1);
        check("t6_pre_count", note_count, 1);
        check("t6_pre_valid", nif.note_valid, 1);
        #1 rst_n = 1'b0;
        #0.5;
        check("t6_rst_busy", busy, 0);
        check("t6_rst_valid", nif.note_valid, 0);
        check("t6_rst_denom", nif.note_denom, 0);
        check("t6_rst_count", note_count, 0);
        check("t6_rst_pulses", {done, error, aborted}, 0);
        tick();
        rst_n = 1'b1;
        extra = 0;
        repeat (8) begin
            tick();
            if (busy || nif.note_valid || done || error || aborted) extra++;
        end
        check("t6_no_restart", extra, 0);

        check("idle_denom_zero", idle_denom_bad, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
